// File: rtl/fifo_psram_lbuf_v2.sv
// Width-converting FIFO: one wide word written per cycle, read out as RATIO narrow subwords, least-significant first.
// Latency: rd_data/rd_valid appear one cycle after an accepted read. Writes are dropped while full and reads while empty; both set sticky flags.
// Ports: clk, rst (sync, active-high), flush, wr_en/wr_data, rd_en/rd_data/rd_valid, full, empty, level, ovf, udf.
module fifo_psram_lbuf_v2 #(
    parameter  int DW_W  = 32,
    parameter  int RATIO = 2,
    parameter  int AW_W  = 7,
    localparam int DW_R  = DW_W / RATIO,
    localparam int SH    = $clog2(RATIO),
    localparam int AR_W  = AW_W + SH,
    localparam int LV_W  = AR_W + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            wr_en,
    input  logic [DW_W-1:0] wr_data,
    input  logic            rd_en,
    output logic [DW_R-1:0] rd_data,
    output logic            rd_valid,
    output logic            full,
    output logic            empty,
    output logic [LV_W-1:0] level,
    output logic            ovf,
    output logic            udf
);

    localparam int              DEPTH    = 1 << AW_W;
    localparam int              SEL_W    = (SH > 0) ? SH : 1;
    // Full means fewer than RATIO narrow slots remain, so one more wide word would not fit.
    localparam logic [LV_W-1:0] FULL_THR = LV_W'((1 << AR_W) - RATIO);
    localparam logic [LV_W-1:0] RATIO_LV = LV_W'(RATIO);

    logic [DW_W-1:0] mem [DEPTH];

    logic [AW_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [AR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LV_W-1:0] level_q, level_d;
    logic            rd_valid_q, rd_valid_d;
    logic            ovf_q, ovf_d;
    logic            udf_q, udf_d;
    logic [SEL_W-1:0] rd_sel_q, rd_sel_d;
    logic [DW_W-1:0] rd_word_q;

    logic            wr_acc;
    logic            rd_acc;
    logic [AW_W-1:0] rd_addr;
    logic [SEL_W-1:0] cur_sel;

    // Upper read-pointer bits pick the wide word, lower bits pick the subword.
    assign rd_addr = rd_ptr_q[AR_W-1:SH];

    generate
        if (SH > 0) begin : g_sel
            assign cur_sel = rd_ptr_q[SEL_W-1:0];
        end else begin : g_nosel
            assign cur_sel = '0;
        end
    endgenerate

    // Flags depend only on the registered level, never on this cycle's requests.
    assign full  = (level_q > FULL_THR);
    assign empty = (level_q == '0);

    assign wr_acc = wr_en && !full  && !flush;
    assign rd_acc = rd_en && !empty && !flush;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        rd_sel_d   = rd_sel_q;
        rd_valid_d = 1'b0;
        ovf_d      = ovf_q;
        udf_d      = udf_q;
        if (flush) begin
            // Contents are discarded; sticky flags and the last read data survive.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                rd_sel_d = cur_sel;
            end
            level_d    = level_q + (wr_acc ? RATIO_LV : '0) - LV_W'(rd_acc);
            rd_valid_d = rd_acc;
            ovf_d      = ovf_q | (wr_en & full);
            udf_d      = udf_q | (rd_en & empty);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_sel_q   <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            rd_word_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rd_sel_q   <= rd_sel_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            // Registered RAM read port; only loads on an accepted read so rd_data holds otherwise.
            if (rd_acc) begin
                rd_word_q <= mem[rd_addr];
            end
        end
    end

    // RAM array is never reset; rst only blocks the write.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    logic [RATIO-1:0][DW_R-1:0] rd_split;
    assign rd_split = rd_word_q;

    assign rd_data  = rd_split[rd_sel_q];
    assign rd_valid = rd_valid_q;
    assign level    = level_q;
    assign ovf      = ovf_q;
    assign udf      = udf_q;

endmodule

// File: tb/tb_fifo_psram_lbuf_v2.sv
module tb_fifo_psram_lbuf_v2;

    logic        clk = 1'b0;
    logic        rst;
    // default instance: DW_W=32, RATIO=2, AW_W=7
    logic        flush, wr_en, rd_en;
    logic [31:0] wr_data;
    logic [15:0] rd_data;
    logic        rd_valid, full, empty, ovf, udf;
    logic [8:0]  level;
    // RATIO=4 instance
    logic        flush4, wr_en4, rd_en4;
    logic [31:0] wr_data4;
    logic [7:0]  rd_data4;
    logic        rd_valid4, full4, empty4, ovf4, udf4;
    logic [9:0]  level4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifo_psram_lbuf_v2 u_dut (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
        .empty(empty), .level(level), .ovf(ovf), .udf(udf)
    );

    fifo_psram_lbuf_v2 #(.DW_W(32), .RATIO(4), .AW_W(7)) u_dut4 (
        .clk(clk), .rst(rst), .flush(flush4), .wr_en(wr_en4), .wr_data(wr_data4),
        .rd_en(rd_en4), .rd_data(rd_data4), .rd_valid(rd_valid4), .full(full4),
        .empty(empty4), .level(level4), .ovf(ovf4), .udf(udf4)
    );

    // Advance one clock edge; outputs are then sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        flush4 = 1'b0; wr_en4 = 1'b0; rd_en4 = 1'b0; wr_data4 = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (level !== 9'd0)     begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
        checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (full !== 1'b0)      begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (rd_valid !== 1'b0)  begin errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        checks++; if (rd_data !== 16'h0)  begin errors++; $display("FAIL reset_rd_data: got %h want 0000", rd_data); end
        checks++; if (ovf !== 1'b0 || udf !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovf=%b udf=%b want 0 0", ovf, udf); end
    endtask

    task automatic test_basic();
        logic [15:0] exp_d [4];
        exp_d[0] = 16'h1111; exp_d[1] = 16'h2222; exp_d[2] = 16'h3333; exp_d[3] = 16'h4444;
        do_reset();
        wr_en = 1'b1; wr_data = 32'h22221111; tick();
        wr_data = 32'h44443333; tick();
        wr_en = 1'b0;
        checks++; if (level !== 9'd4) begin errors++; $display("FAIL basic_level4: got %0d want 4", level); end
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp_d[i]) begin
                errors++; $display("FAIL basic_read%0d: got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, exp_d[i]);
            end
        end
        rd_en = 1'b0;
        checks++; if (level !== 9'd0 || empty !== 1'b1) begin errors++; $display("FAIL basic_end: got level=%0d empty=%b want 0 1", level, empty); end
        tick();
        checks++; if (rd_valid !== 1'b0 || rd_data !== 16'h4444) begin errors++; $display("FAIL basic_hold: got v=%b d=%h want v=0 d=4444", rd_valid, rd_data); end
    endtask

    task automatic test_fill();
        do_reset();
        wr_en = 1'b1;
        for (int i = 0; i < 128; i++) begin
            wr_data = {16'(2*i+1), 16'(2*i)};
            tick();
        end
        checks++; if (level !== 9'd256 || full !== 1'b1) begin errors++; $display("FAIL fill_full: got level=%0d full=%b want 256 1", level, full); end
        wr_data = 32'hDEADBEEF;
        tick();
        wr_en = 1'b0;
        checks++; if (ovf !== 1'b1 || level !== 9'd256) begin errors++; $display("FAIL fill_ovf: got ovf=%b level=%0d want 1 256", ovf, level); end
        rd_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            tick();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 16'(i)) begin
                errors++; $display("FAIL fill_read%0d: got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, 16'(i));
            end
        end
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fill_empty: got %b want 1", empty); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] q[$];
        logic [15:0] n;
        logic [15:0] want;
        int m_level;
        int max_level;
        bit w_acc, r_acc;
        do_reset();
        n = 16'd0;
        wr_en = 1'b1;
        for (int i = 0; i < 50; i++) begin
            wr_data = {n + 16'd1, n};
            q.push_back(n); q.push_back(n + 16'd1);
            n = n + 16'd2;
            tick();
        end
        wr_en = 1'b0;
        m_level = 100;
        max_level = 100;
        checks++; if (level !== 9'd100) begin errors++; $display("FAIL b2b_start: got %0d want 100", level); end
        for (int c = 0; c < 600; c++) begin
            // A write fits only if at least two narrow slots are free: level <= 254.
            w_acc = (m_level <= 254);
            r_acc = (m_level > 0);
            wr_en = w_acc;
            rd_en = 1'b1;
            wr_data = {n + 16'd1, n};
            if (w_acc) begin
                q.push_back(n); q.push_back(n + 16'd1);
                n = n + 16'd2;
            end
            tick();
            m_level = m_level + (w_acc ? 2 : 0) - (r_acc ? 1 : 0);
            if (m_level > max_level) max_level = m_level;
            if (r_acc) begin
                want = q.pop_front();
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== want) begin
                    errors++; $display("FAIL b2b_data c=%0d: got v=%b d=%h want v=1 d=%h", c, rd_valid, rd_data, want);
                end
            end
            checks++;
            if (level !== 9'(m_level)) begin
                errors++; $display("FAIL b2b_level c=%0d: got %0d want %0d", c, level, m_level);
            end
        end
        wr_en = 1'b0; rd_en = 1'b0;
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b want 0", ovf); end
        checks++; if (max_level != 255) begin errors++; $display("FAIL b2b_max_level: got %0d want 255", max_level); end
    endtask

    task automatic test_underflow();
        do_reset();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (rd_valid !== 1'b0 || rd_data !== 16'h0) begin errors++; $display("FAIL udf_read: got v=%b d=%h want v=0 d=0000", rd_valid, rd_data); end
        checks++; if (udf !== 1'b1) begin errors++; $display("FAIL udf_set: got %b want 1", udf); end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (udf !== 1'b0) begin errors++; $display("FAIL udf_clear: got %b want 0", udf); end
    endtask

    task automatic test_flush();
        do_reset();
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        wr_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wr_data = 32'h10000000 + 32'(i);
            tick();
        end
        checks++; if (level !== 9'd20) begin errors++; $display("FAIL flush_pre_level: got %0d want 20", level); end
        flush = 1'b1; wr_data = 32'hCCCCCCCC; rd_en = 1'b1;
        tick();
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        checks++; if (level !== 9'd0 || empty !== 1'b1) begin errors++; $display("FAIL flush_level: got level=%0d empty=%b want 0 1", level, empty); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL flush_rd_valid: got %b want 0", rd_valid); end
        checks++; if (udf !== 1'b1) begin errors++; $display("FAIL flush_udf_kept: got %b want 1", udf); end
        wr_en = 1'b1; wr_data = 32'hBBBBAAAA; tick(); wr_en = 1'b0;
        checks++; if (level !== 9'd2) begin errors++; $display("FAIL flush_post_level: got %0d want 2", level); end
        rd_en = 1'b1;
        tick();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 16'hAAAA) begin errors++; $display("FAIL flush_read0: got v=%b d=%h want v=1 d=aaaa", rd_valid, rd_data); end
        tick();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 16'hBBBB) begin errors++; $display("FAIL flush_read1: got v=%b d=%h want v=1 d=bbbb", rd_valid, rd_data); end
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_end_empty: got %b want 1", empty); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        wr_en = 1'b1; wr_data = 32'h87654321; tick();
        wr_data = 32'h0FEDCBA9; tick();
        wr_en = 1'b0;
        rd_en = 1'b1; tick();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 16'h4321) begin errors++; $display("FAIL rmid_pre: got v=%b d=%h want v=1 d=4321", rd_valid, rd_data); end
        rst = 1'b1; wr_en = 1'b1; tick();
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        checks++; if (rd_valid !== 1'b0 || rd_data !== 16'h0) begin errors++; $display("FAIL rmid_read: got v=%b d=%h want v=0 d=0000", rd_valid, rd_data); end
        checks++; if (level !== 9'd0 || empty !== 1'b1) begin errors++; $display("FAIL rmid_level: got level=%0d empty=%b want 0 1", level, empty); end
    endtask

    task automatic test_ratio4();
        logic [7:0] exp_b [4];
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
        do_reset();
        wr_en4 = 1'b1; wr_data4 = 32'h44332211; tick(); wr_en4 = 1'b0;
        checks++; if (level4 !== 10'd4) begin errors++; $display("FAIL r4_level4: got %0d want 4", level4); end
        rd_en4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (rd_valid4 !== 1'b1 || rd_data4 !== exp_b[i]) begin
                errors++; $display("FAIL r4_read%0d: got v=%b d=%h want v=1 d=%h", i, rd_valid4, rd_data4, exp_b[i]);
            end
        end
        rd_en4 = 1'b0;
        wr_en4 = 1'b1;
        for (int i = 0; i < 127; i++) begin
            wr_data4 = 32'(i);
            tick();
        end
        wr_en4 = 1'b0;
        checks++; if (level4 !== 10'd508 || full4 !== 1'b0) begin errors++; $display("FAIL r4_508: got level=%0d full=%b want 508 0", level4, full4); end
        wr_en4 = 1'b1; tick(); wr_en4 = 1'b0;
        checks++; if (level4 !== 10'd512 || full4 !== 1'b1) begin errors++; $display("FAIL r4_512: got level=%0d full=%b want 512 1", level4, full4); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_back_to_back();
        test_underflow();
        test_flush();
        test_reset_mid();
        test_ratio4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_psram_lbuf_v2.md
FIFO_PSRAM_LBUF_V2 -- requirements
Module: fifo_psram_lbuf_v2

Interface
REQ-001 SHALL expose parameter DW_W, default 32: write-port data width in bits.
REQ-002 SHALL expose parameter RATIO, default 2: write-to-read width ratio; legal values 1, 2, 4.
REQ-003 SHALL expose parameter AW_W, default 7: write-side address width; depth 2^AW_W wide words.
REQ-004 SHALL derive DW_R = DW_W/RATIO, AR_W = AW_W + log2(RATIO) and LV_W = AR_W + 1.
REQ-005 SHALL provide the following ports; one clock; reset is synchronous and active-high:
  clk  input  1  single clock for all logic
  rst  input  1  synchronous active-high reset
  flush  input  1  synchronous clear of contents; flags preserved
  wr_en  input  1  write one wide word
  wr_data  input  DW_W  wide write data
  rd_en  input  1  read one narrow word
  rd_data  output  DW_R  narrow read data
  rd_valid  output  1  rd_data updated this cycle
  full  output  1  fewer than RATIO narrow slots free
  empty  output  1  no narrow words stored
  level  output  LV_W  stored narrow-word count
  ovf  output  1  sticky: write attempted while full
  udf  output  1  sticky: read attempted while empty

Function
REQ-006 SHALL store data in one inferred simple-dual-port RAM of 2^AW_W x DW_W; narrow read selects subword by low log2(RATIO) read-pointer bits.
REQ-007 SHALL emit subwords least-significant first: wide word W yields W[DW_R-1:0], then W[2*DW_R-1:DW_R], and so on.
REQ-008 SHALL keep a write pointer of AW_W bits and a read pointer of AR_W bits, both wrapping modulo their range with no gap.
REQ-009 SHALL accept a write when wr_en=1 and full=0: RAM written, write pointer +1, level +RATIO.
REQ-010 SHALL accept a read when rd_en=1 and empty=0: read pointer +1, level -1.
REQ-011 SHALL present read data with latency 1: rd_data and rd_valid=1 on the cycle after an accepted read.
REQ-012 SHALL hold rd_data unchanged and drive rd_valid=0 in cycles after no accepted read.
REQ-013 SHALL, on simultaneous accepted write and read, update level by +RATIO-1 in one cycle.
REQ-014 SHALL evaluate full and empty from the registered level before the current cycle's operation; a write to a FIFO one read short of full is rejected even when a read is accepted in the same cycle.
REQ-015 SHALL compute full = (level > 2^AR_W - RATIO) and empty = (level == 0), both registered-derived, with no combinational path from wr_en or rd_en.
REQ-016 SHALL ignore a write while full (no pointer, RAM or level change) and set ovf=1.
REQ-017 SHALL ignore a read while empty (rd_valid=0, rd_data held) and set udf=1.
REQ-018 SHALL keep ovf and udf set until rst; flush does not clear them.
REQ-019 SHALL, when flush=1, zero both pointers and level next cycle, force rd_valid=0, ignore same-cycle wr_en and rd_en, and hold rd_data.
REQ-020 SHALL return the write-first value when a read addresses the wide word written in the same cycle; this cannot occur with level tracking, and the RAM mode is unconstrained.

Reset
REQ-021 SHALL, on rst=1 at a clk edge, set both pointers to 0, level=0, empty=1, full=0, rd_valid=0, rd_data=0, ovf=0, udf=0.
REQ-022 SHALL give rst priority over flush, wr_en and rd_en; RAM contents are not cleared.
REQ-023 SHALL, on rst asserted mid-transfer, discard the in-flight read, with rd_valid=0 on the following cycle.

Verification
REQ-024 Defaults; write 0x22221111 then 0x44443333; read 4 back-to-back -> rd_data 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles, each one cycle after rd_en; level 4 -> 0; empty=1 at end.
REQ-025 Defaults; write 128 words -> level=256 and full=1; 129th write -> ignored, ovf=1, level stays 256; read 256 -> data matches in order; final empty=1.
REQ-026 Defaults; keep level=100 while asserting wr_en and rd_en every cycle for 600 cycles (pointer wrap) -> level +1 per cycle until full, no data loss or reorder, ovf=0.
REQ-027 Read while empty after reset -> rd_valid=0, rd_data=0, udf=1; then rst -> udf=0.
REQ-028 Defaults; write 10 words, flush with wr_en=1 -> level=0, empty=1, flushed-cycle write dropped; next write 0xBBBBAAAA then reads -> 0xAAAA, 0xBBBB.
REQ-029 RATIO=4, DW_W=32; write 0x44332211 -> reads 0x11, 0x22, 0x33, 0x44; full asserts once level exceeds 508.
